// File: rtl/fib_gen_pkg.sv
// rtl/fib_gen_pkg.sv - shared types and helpers for the Fibonacci residue-filter generators
package fib_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_VALUE = 0;
    localparam int MODE_COUNT = 1;

    // One spare bit so the unreduced sum of two residues never wraps.
    function automatic int res_width(input int modulus);
        return $clog2(modulus) + 1;
    endfunction

endpackage

// File: rtl/fib_mod_gen_if.sv
// rtl/fib_mod_gen_if.sv - generator handshake bundle for fib_mod_gen
interface fib_mod_gen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] n;
    logic             __start;
    logic             __ready;
    logic             __valid;
    logic             __done;
    logic [WIDTH-1:0] __output_0;
    logic             __overflow;

    modport master (
        output n, __start, __ready,
        input  __valid, __done, __output_0, __overflow
    );

    modport slave (
        input  n, __start, __ready,
        output __valid, __done, __output_0, __overflow
    );
endinterface

// File: rtl/fib_mod_gen_mod_add.sv
// rtl/fib_mod_gen_mod_add.sv - combinational modular add for operands already below M
module mod_add #(
    parameter int M = 2,
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s
);
    logic [W-1:0] sum;

    // Both operands are below M, so one conditional subtract fully reduces the sum.
    always_comb begin
        sum = x + y;
        s   = (sum >= W'(M)) ? (sum - W'(M)) : sum;
    end
endmodule

// File: rtl/fib_mod_gen.sv
// rtl/fib_mod_gen.sv - Fibonacci walker emitting terms with a chosen residue
module fib_mod_gen
    import fib_gen_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MODULUS    = 2,
    parameter int REMAINDER  = 0,
    parameter int COUNT_MODE = 0
) (
    input  logic          __clock,
    input  logic          __reset,
    fib_mod_gen_if.slave  bus
);
    localparam int            RW      = res_width(MODULUS);
    localparam logic [RW-1:0] REM_R   = RW'(REMAINDER);
    localparam logic [RW-1:0] RB_INIT = RW'(1 % MODULUS);

    state_t           state;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] cnt;
    logic [RW-1:0]    ra;
    logic [RW-1:0]    rb;
    logic [RW-1:0]    rsum;
    logic             ovf_pending;
    logic [WIDTH:0]   sum_ab;
    logic             terminate;
    logic             stalled;

    // Residues track a and b so the filter never needs a divider.
    mod_add #(
        .M (MODULUS),
        .W (RW)
    ) u_mod_add (
        .x (ra),
        .y (rb),
        .s (rsum)
    );

    // Next-term sum with carry, stop condition for the current term, and stall detect.
    always_comb begin
        sum_ab  = {1'b0, a} + {1'b0, b};
        stalled = bus.__valid && !bus.__ready;
        if (COUNT_MODE == MODE_COUNT) begin
            terminate = ovf_pending || (cnt == lim);
        end else begin
            terminate = ovf_pending || (a >= lim);
        end
    end

    // Run control: one term per unstalled cycle, outputs registered alongside state.
    always_ff @(posedge __clock) begin
        if (__reset) begin
            state          <= IDLE;
            lim            <= '0;
            a              <= '0;
            b              <= '0;
            cnt            <= '0;
            ra             <= '0;
            rb             <= '0;
            ovf_pending    <= 1'b0;
            bus.__valid    <= 1'b0;
            bus.__done     <= 1'b0;
            bus.__output_0 <= '0;
            bus.__overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.__start) begin
                        lim            <= bus.n;
                        a              <= '0;
                        b              <= WIDTH'(1);
                        ra             <= '0;
                        rb             <= RB_INIT;
                        cnt            <= '0;
                        ovf_pending    <= 1'b0;
                        bus.__overflow <= 1'b0;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (!stalled) begin
                        if (terminate) begin
                            bus.__valid    <= 1'b1;
                            bus.__done     <= 1'b1;
                            bus.__output_0 <= '0;
                            bus.__overflow <= ovf_pending;
                            state          <= DONE;
                        end else begin
                            if (ra == REM_R) begin
                                bus.__valid    <= 1'b1;
                                bus.__output_0 <= a;
                                cnt            <= cnt + WIDTH'(1);
                            end else begin
                                bus.__valid <= 1'b0;
                            end
                            a           <= b;
                            b           <= sum_ab[WIDTH-1:0];
                            ovf_pending <= sum_ab[WIDTH];
                            ra          <= rb;
                            rb          <= rsum;
                        end
                    end
                end
                DONE: begin
                    if (bus.__ready) begin
                        bus.__valid <= 1'b0;
                        bus.__done  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_mod_gen.sv
// tb/tb_fib_mod_gen.sv - scoreboard bench for fib_mod_gen
module tb_fib_mod_gen;
    import fib_gen_pkg::*;

    typedef struct packed {
        logic        done;
        logic [31:0] data;
        logic        ovf;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    vectors = 0;
    int    miscompares = 0;
    beat_t sb0[$];
    beat_t sb1[$];
    beat_t sb2[$];
    logic        stall0 = 1'b0;
    logic [31:0] hold0 = '0;

    always #5 clk = ~clk;

    fib_mod_gen_if #(.WIDTH(32)) if0 ();
    fib_mod_gen_if #(.WIDTH(32)) if1 ();
    fib_mod_gen_if #(.WIDTH(8))  if2 ();

    fib_mod_gen #(.WIDTH(32), .MODULUS(2), .REMAINDER(0), .COUNT_MODE(MODE_VALUE))
        u0 (.__clock(clk), .__reset(rst), .bus(if0));
    fib_mod_gen #(.WIDTH(32), .MODULUS(3), .REMAINDER(0), .COUNT_MODE(MODE_COUNT))
        u1 (.__clock(clk), .__reset(rst), .bus(if1));
    fib_mod_gen #(.WIDTH(8), .MODULUS(2), .REMAINDER(0), .COUNT_MODE(MODE_COUNT))
        u2 (.__clock(clk), .__reset(rst), .bus(if2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic push(input int idx, input logic done, input logic [31:0] data, input logic ovf);
        beat_t e;
        e.done = done;
        e.data = data;
        e.ovf  = ovf;
        case (idx)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic push_data(input int idx, input logic [31:0] v);
        push(idx, 1'b0, v, 1'b0);
    endtask

    task automatic check_beat(input int idx, input logic done, input logic [31:0] data, input logic ovf);
        beat_t e;
        if (qsize(idx) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d_unexpected_beat: got data %0d done %0d, expected no beat", idx, data, done);
            return;
        end
        case (idx)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
        chk($sformatf("dut%0d_done", idx), {31'b0, done}, {31'b0, e.done});
        chk($sformatf("dut%0d_output", idx), data, e.data);
        chk($sformatf("dut%0d_overflow", idx), {31'b0, ovf}, {31'b0, e.ovf});
    endtask

    // Monitors: compare every transferred beat; dut0 also checks that stalled beats hold.
    always @(negedge clk) begin
        if (stall0) begin
            chk("dut0_stall_valid", {31'b0, if0.__valid}, 32'd1);
            chk("dut0_stall_hold", if0.__output_0, hold0);
        end
        stall0 = (if0.__valid === 1'b1) && (if0.__ready === 1'b0) && !rst;
        hold0  = if0.__output_0;
        if ((if0.__valid === 1'b1) && if0.__ready && !rst)
            check_beat(0, if0.__done, if0.__output_0, if0.__overflow);
    end

    always @(negedge clk) begin
        if ((if1.__valid === 1'b1) && if1.__ready && !rst)
            check_beat(1, if1.__done, if1.__output_0, if1.__overflow);
    end

    always @(negedge clk) begin
        if ((if2.__valid === 1'b1) && if2.__ready && !rst)
            check_beat(2, if2.__done, {24'b0, if2.__output_0}, if2.__overflow);
    end

    task automatic pulse_start(input int idx, input logic [31:0] nval);
        case (idx)
            0:       begin if0.n = nval;      if0.__start = 1'b1; end
            1:       begin if1.n = nval;      if1.__start = 1'b1; end
            default: begin if2.n = nval[7:0]; if2.__start = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if0.__start = 1'b0;
        if1.__start = 1'b0;
        if2.__start = 1'b0;
    endtask

    task automatic wait_empty(input int idx);
        for (int i = 0; i < 300; i++) begin
            if (qsize(idx) == 0) return;
            @(posedge clk);
            #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL dut%0d_timeout: got %0d beats outstanding, expected 0", idx, qsize(idx));
        case (idx)
            0:       sb0.delete();
            1:       sb1.delete();
            default: sb2.delete();
        endcase
    endtask

    task automatic check_idle(input int idx);
        case (idx)
            0: begin
                chk("dut0_idle_valid", {31'b0, if0.__valid}, 32'd0);
                chk("dut0_idle_done", {31'b0, if0.__done}, 32'd0);
            end
            1: begin
                chk("dut1_idle_valid", {31'b0, if1.__valid}, 32'd0);
                chk("dut1_idle_done", {31'b0, if1.__done}, 32'd0);
            end
            default: begin
                chk("dut2_idle_valid", {31'b0, if2.__valid}, 32'd0);
                chk("dut2_idle_done", {31'b0, if2.__done}, 32'd0);
            end
        endcase
    endtask

    initial begin
        if0.n = '0; if0.__start = 1'b0; if0.__ready = 1'b1;
        if1.n = '0; if1.__start = 1'b0; if1.__ready = 1'b1;
        if2.n = '0; if2.__start = 1'b0; if2.__ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", {31'b0, if0.__valid}, 32'd0);
        chk("rst_done0", {31'b0, if0.__done}, 32'd0);
        chk("rst_out0", if0.__output_0, 32'd0);
        chk("rst_ovf0", {31'b0, if0.__overflow}, 32'd0);
        chk("rst_valid1", {31'b0, if1.__valid}, 32'd0);
        chk("rst_valid2", {31'b0, if2.__valid}, 32'd0);
        chk("rst_ovf2", {31'b0, if2.__overflow}, 32'd0);
        rst = 1'b0;

        // Value bound n=40, with a start pulse during RUN that must be ignored.
        push_data(0, 0); push_data(0, 2); push_data(0, 8); push_data(0, 34);
        push(0, 1'b1, 32'd0, 1'b0);
        pulse_start(0, 40);
        @(posedge clk);
        #1;
        pulse_start(0, 5);
        wait_empty(0);
        check_idle(0);

        // Backpressure: hold beat 2 for three cycles.
        push_data(0, 0); push_data(0, 2); push_data(0, 8); push_data(0, 34);
        push(0, 1'b1, 32'd0, 1'b0);
        pulse_start(0, 40);
        for (int i = 0; i < 50; i++) begin
            if (if0.__valid && if0.__output_0 == 32'd2) break;
            @(posedge clk);
            #1;
        end
        chk("bp_found_2", if0.__output_0, 32'd2);
        if0.__ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if0.__ready = 1'b1;
        wait_empty(0);
        check_idle(0);

        // Count mode, modulus 3: first three multiples of 3.
        push_data(1, 0); push_data(1, 3); push_data(1, 21);
        push(1, 1'b1, 32'd0, 1'b0);
        pulse_start(1, 3);
        wait_empty(1);
        check_idle(1);

        // n=0 in both modes: terminal beat only.
        push(1, 1'b1, 32'd0, 1'b0);
        pulse_start(1, 0);
        wait_empty(1);
        push(0, 1'b1, 32'd0, 1'b0);
        pulse_start(0, 0);
        wait_empty(0);

        // Overflow at 8 bits: 233+144 carries, so 144 is last.
        push_data(2, 0); push_data(2, 2); push_data(2, 8); push_data(2, 34); push_data(2, 144);
        push(2, 1'b1, 32'd0, 1'b1);
        pulse_start(2, 20);
        wait_empty(2);
        chk("ovf_sticky_a", {31'b0, if2.__overflow}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky_b", {31'b0, if2.__overflow}, 32'd1);
        push(2, 1'b1, 32'd0, 1'b0);
        pulse_start(2, 0);
        chk("ovf_cleared", {31'b0, if2.__overflow}, 32'd0);
        wait_empty(2);

        // Reset mid-run after beat 8, then a fresh short run.
        push_data(0, 0); push_data(0, 2); push_data(0, 8);
        pulse_start(0, 1000);
        wait_empty(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", {31'b0, if0.__valid}, 32'd0);
        chk("midrst_done", {31'b0, if0.__done}, 32'd0);
        chk("midrst_out", if0.__output_0, 32'd0);
        chk("midrst_ovf", {31'b0, if0.__overflow}, 32'd0);
        push_data(0, 0); push_data(0, 2); push_data(0, 8);
        push(0, 1'b1, 32'd0, 1'b0);
        pulse_start(0, 10);
        wait_empty(0);
        check_idle(0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
